// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: one owner at a time among init, refresh, write and read.
// The owner's command/address/bank are muxed to the pins by the current state.
module sdram_arbit #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [3:0]  CMD_NOP    = 4'b0111
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            init_cmd,
   input  logic [ADDR_WIDTH-1:0] init_addr,
   input  logic                  init_end,
   input  logic                  ref_rq,
   input  logic [3:0]            ref_cmd,
   input  logic [ADDR_WIDTH-1:0] ref_addr,
   input  logic                  ref_end,
   input  logic                  wr_rq,
   input  logic [3:0]            wr_cmd,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [1:0]            wr_bank_addr,
   input  logic                  wr_end,
   input  logic                  rd_rq,
   input  logic [3:0]            rd_cmd,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [1:0]            rd_bank_addr,
   input  logic                  rd_end,
   output logic                  ref_en,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic [3:0]            sdram_cmd,
   output logic [ADDR_WIDTH-1:0] sdram_addr,
   output logic [1:0]            sdram_bank,
   output logic                  sdram_cke,
   output logic [2:0]            arb_state
);

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      ARBIT = 3'd1,
      AREF  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4
   } state_t;

   state_t state, state_nxt;
   logic   last_rd;   // 1: read owned the bus last, so write wins a tie
   logic   ref_go, wr_go, rd_go;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      ref_go    = 1'b0;
      wr_go     = 1'b0;
      rd_go     = 1'b0;
      case (state)
         INIT:  if (init_end) state_nxt = ARBIT;
         ARBIT: begin
            if (ref_rq) begin
               ref_go    = 1'b1;
               state_nxt = AREF;
            end else if (wr_rq && (!rd_rq || last_rd)) begin
               wr_go     = 1'b1;
               state_nxt = WRITE;
            end else if (rd_rq) begin
               rd_go     = 1'b1;
               state_nxt = READ;
            end
         end
         AREF:    if (ref_end) state_nxt = ARBIT;
         WRITE:   if (wr_end)  state_nxt = ARBIT;
         READ:    if (rd_end)  state_nxt = ARBIT;
         default: state_nxt = INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         last_rd   <= 1'b1;
         ref_en    <= 1'b0;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         sdram_cke <= 1'b0;
      end else begin
         state     <= state_nxt;
         ref_en    <= ref_go;
         wr_en     <= wr_go;
         rd_en     <= rd_go;
         sdram_cke <= 1'b1;
         if (wr_go) last_rd <= 1'b0;
         else if (rd_go) last_rd <= 1'b1;
      end
   end

   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_addr = '0;
      sdram_bank = 2'b00;
      case (state)
         INIT: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         AREF: begin
            sdram_cmd  = ref_cmd;
            sdram_addr = ref_addr;
         end
         WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_addr = wr_addr;
            sdram_bank = wr_bank_addr;
         end
         READ: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
            sdram_bank = rd_bank_addr;
         end
         default: ;
      endcase
   end

   assign arb_state = state;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed scenarios plus random traffic
// compared each cycle against a transaction-level ownership model.
module tb_sdram_arbit;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    init_cmd, ref_cmd, wr_cmd, rd_cmd;
   logic [AW-1:0] init_addr, ref_addr, wr_addr, rd_addr;
   logic [1:0]    wr_bank_addr, rd_bank_addr;
   logic          init_end, ref_rq, ref_end, wr_rq, wr_end, rd_rq, rd_end;
   logic          ref_en, wr_en, rd_en, sdram_cke;
   logic [3:0]    sdram_cmd;
   logic [AW-1:0] sdram_addr;
   logic [1:0]    sdram_bank;
   logic [2:0]    arb_state;

   sdram_arbit #(.ADDR_WIDTH(AW), .CMD_NOP(4'b0111)) dut (
      .clk(clk), .rst_n(rst_n),
      .init_cmd(init_cmd), .init_addr(init_addr), .init_end(init_end),
      .ref_rq(ref_rq), .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_end(ref_end),
      .wr_rq(wr_rq), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank_addr(wr_bank_addr),
      .wr_end(wr_end),
      .rd_rq(rd_rq), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank_addr(rd_bank_addr),
      .rd_end(rd_end),
      .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
      .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
      .sdram_cke(sdram_cke), .arb_state(arb_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: who owns the bus (0 init, 1 none, 2 refresh, 3 write, 4 read).
   int owner;
   bit read_was_last;
   bit cke_exp, g_ref, g_wr, g_rd;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [3:0]    c;
      logic [AW-1:0] a;
      logic [1:0]    b;
      c = 4'b0111; a = '0; b = 2'b00;
      if (owner == 0) begin c = init_cmd; a = init_addr; end
      if (owner == 2) begin c = ref_cmd;  a = ref_addr;  end
      if (owner == 3) begin c = wr_cmd;   a = wr_addr;   b = wr_bank_addr; end
      if (owner == 4) begin c = rd_cmd;   a = rd_addr;   b = rd_bank_addr; end
      check({tag, "/state"}, 32'(arb_state), 32'(owner));
      check({tag, "/grants"}, {29'd0, ref_en, wr_en, rd_en}, {29'd0, g_ref, g_wr, g_rd});
      check({tag, "/cke"}, 32'(sdram_cke), 32'(cke_exp));
      check({tag, "/cmd"}, 32'(sdram_cmd), 32'(c));
      check({tag, "/addr"}, 32'(sdram_addr), 32'(a));
      check({tag, "/bank"}, 32'(sdram_bank), 32'(b));
   endtask

   task automatic model_reset();
      owner = 0; read_was_last = 1'b1; cke_exp = 1'b0;
      g_ref = 1'b0; g_wr = 1'b0; g_rd = 1'b0;
   endtask

   // One clock: predict from pre-edge inputs, advance, then compare.
   task automatic tick(string tag);
      int nxt;
      bit gr, gw, gd;
      nxt = owner; gr = 1'b0; gw = 1'b0; gd = 1'b0;
      if (owner == 0 && init_end) nxt = 1;
      else if (owner == 2 && ref_end) nxt = 1;
      else if (owner == 3 && wr_end) nxt = 1;
      else if (owner == 4 && rd_end) nxt = 1;
      else if (owner == 1) begin
         if (ref_rq) gr = 1'b1;
         else if (wr_rq && rd_rq) begin
            if (read_was_last) gw = 1'b1; else gd = 1'b1;
         end else if (wr_rq) gw = 1'b1;
         else if (rd_rq) gd = 1'b1;
         if (gr) nxt = 2;
         if (gw) nxt = 3;
         if (gd) nxt = 4;
      end
      @(posedge clk);
      #1;
      owner = nxt; g_ref = gr; g_wr = gw; g_rd = gd; cke_exp = 1'b1;
      if (gw) read_was_last = 1'b0;
      if (gd) read_was_last = 1'b1;
      check_all(tag);
   endtask

   task automatic clear_inputs();
      init_cmd = 4'b0111; init_addr = '0; init_end = 1'b0;
      ref_rq = 1'b0; ref_cmd = 4'b0001; ref_addr = 12'h400; ref_end = 1'b0;
      wr_rq = 1'b0; wr_cmd = 4'b0100; wr_addr = 12'h111; wr_bank_addr = 2'b01; wr_end = 1'b0;
      rd_rq = 1'b0; rd_cmd = 4'b0101; rd_addr = 12'h222; rd_bank_addr = 2'b10; rd_end = 1'b0;
   endtask

   initial begin
      int exp_order [4];
      int seen;
      clear_inputs();
      model_reset();
      rst_n = 1'b0;
      #12;
      check_all("reset");
      check("reset_cke", 32'(sdram_cke), 32'd0);

      // Power-up: init command reaches the pins, init_end moves to ARBIT.
      @(posedge clk); #1;
      rst_n = 1'b1;
      init_cmd = 4'b0010;
      #1;
      check("init_cmd_pass", 32'(sdram_cmd), 32'h2);
      tick("init_wait");
      init_end = 1'b1;
      tick("init_done");
      check("init_arbit_state", 32'(arb_state), 32'd1);
      check("init_arbit_nop", 32'(sdram_cmd), 32'h7);
      check("init_arbit_cke", 32'(sdram_cke), 32'd1);

      // Write and read both held: strict alternation, write first after reset.
      exp_order = '{3, 4, 3, 4};
      wr_rq = 1'b1; rd_rq = 1'b1;
      for (int k = 0; k < 4; k++) begin
         seen = 0;
         for (int c = 0; c < 6 && seen == 0; c++) begin
            tick("alt_wait");
            if (wr_en) seen = 3;
            else if (rd_en) seen = 4;
         end
         check("alt_order", 32'(seen), 32'(exp_order[k]));
         tick("alt_busy");
         if (exp_order[k] == 3) wr_end = 1'b1; else rd_end = 1'b1;
         if (k == 3) begin wr_rq = 1'b0; rd_rq = 1'b0; end
         tick("alt_end");
         wr_end = 1'b0; rd_end = 1'b0;
      end

      // Refresh beats both; one NOP cycle after ref_end, then write.
      ref_rq = 1'b1; wr_rq = 1'b1; rd_rq = 1'b1;
      tick("ref_grant");
      check("ref_only_grant", {29'd0, ref_en, wr_en, rd_en}, 32'b100);
      check("ref_state", 32'(arb_state), 32'd2);
      ref_rq = 1'b0;
      tick("ref_busy");
      ref_end = 1'b1;
      tick("ref_end");
      ref_end = 1'b0;
      check("ref_nop_state", 32'(arb_state), 32'd1);
      check("ref_nop_cmd", 32'(sdram_cmd), 32'h7);
      tick("post_ref");
      check("post_ref_wr_en", {29'd0, ref_en, wr_en, rd_en}, 32'b010);
      rd_rq = 1'b0; wr_rq = 1'b0; wr_end = 1'b1;
      tick("wr_end");
      wr_end = 1'b0;

      // Read routing; foreign end pulse ignored.
      rd_rq = 1'b1;
      tick("rd_grant");
      rd_rq = 1'b0;
      rd_addr = 12'h0A5; rd_bank_addr = 2'b11;
      #1;
      check("rd_addr_pins", 32'(sdram_addr), 32'h0A5);
      check("rd_bank_pins", 32'(sdram_bank), 32'h3);
      wr_end = 1'b1;
      tick("rd_foreign_end");
      wr_end = 1'b0;
      check("rd_holds", 32'(arb_state), 32'd4);
      rd_end = 1'b1;
      tick("rd_end");
      rd_end = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         ref_rq = ($urandom % 5) == 0;
         wr_rq  = $urandom % 2;
         rd_rq  = $urandom % 2;
         ref_end = ($urandom % 3) == 0;
         wr_end  = ($urandom % 3) == 0;
         rd_end  = ($urandom % 3) == 0;
         init_end = $urandom % 2;
         init_cmd = 4'($urandom); init_addr = AW'($urandom);
         ref_cmd = 4'($urandom); ref_addr = AW'($urandom);
         wr_cmd = 4'($urandom); wr_addr = AW'($urandom); wr_bank_addr = 2'($urandom);
         rd_cmd = 4'($urandom); rd_addr = AW'($urandom); rd_bank_addr = 2'($urandom);
         tick("rand");
      end
      clear_inputs();
      init_end = 1'b1;
      for (int c = 0; c < 4 && owner != 1; c++) begin
         ref_end = 1'b1; wr_end = 1'b1; rd_end = 1'b1;
         tick("drain");
      end
      ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;

      // Asynchronous reset in the middle of a write.
      wr_rq = 1'b1;
      tick("pre_rst_grant");
      tick("pre_rst_busy");
      check("pre_rst_write", 32'(arb_state), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_state", 32'(arb_state), 32'd0);
      check("async_rst_grants", {29'd0, ref_en, wr_en, rd_en}, 32'd0);
      check("async_rst_cke", 32'(sdram_cke), 32'd0);
      check_all("async_rst");
      @(posedge clk); #1;
      check_all("rst_held");
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
